// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding,
// arbitration modes and port identifiers.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int ARB_FIXED = 32'sd0;
    localparam int ARB_RR    = 32'sd1;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational winner selection between the CPU port and the debug port.
// Fixed mode always favours the CPU port; round-robin mode hands a tie to
// the port that did not win last time.
module dmem_rr_pick
    import dmem_pkg::*;
#(
    parameter int ARB_MODE = ARB_RR
) (
    input  logic p0_req,
    input  logic p1_req,
    input  logic last_grant,
    output logic win_id,
    output logic any_req
);

    // Pick the winning port from the live requests and the previous grant.
    always_comb begin
        win_id  = PORT_CPU;
        any_req = p0_req | p1_req;
        if (ARB_MODE == ARB_FIXED) begin
            if (p0_req) begin
                win_id = PORT_CPU;
            end else if (p1_req) begin
                win_id = PORT_DBG;
            end else begin
                win_id = PORT_CPU;
            end
        end else begin
            if (p0_req && p1_req) begin
                win_id = ~last_grant;
            end else if (p1_req) begin
                win_id = PORT_DBG;
            end else begin
                win_id = PORT_CPU;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the 8-bit data memory. Every access is a
// fixed IDLE -> ACCESS -> DONE sequence. All memory-side controls and all
// handshake outputs come straight from flops so the combinationally-written
// memory never sees a decode glitch.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int ARB_MODE = ARB_RR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_enable,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_read_addr,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
);

    state_t              state_r, state_s;
    logic                win_id_s, any_req_s;
    logic                win_id_r, last_grant_r;
    logic                cmd_we_s;
    logic [ADDR_W-1:0]   cmd_addr_s, addr_r;
    logic [DATA_W-1:0]   cmd_wdata_s, wdata_r;
    logic                latch_s, finish_s;
    logic                p0_gnt_s, p1_gnt_s, p0_done_s, p1_done_s;
    logic                mem_en_s, mem_wr_s, busy_s;
    logic                p0_gnt_r, p1_gnt_r, p0_done_r, p1_done_r;
    logic                mem_en_r, mem_wr_r, busy_r;
    logic [DATA_W-1:0]   p0_rdata_r, p1_rdata_r;

    dmem_rr_pick #(
        .ARB_MODE (ARB_MODE)
    ) u_pick (
        .p0_req     (p0_req),
        .p1_req     (p1_req),
        .last_grant (last_grant_r),
        .win_id     (win_id_s),
        .any_req    (any_req_s)
    );

    // Route the winning port's command fields toward the command registers.
    always_comb begin
        cmd_we_s    = p0_we;
        cmd_addr_s  = p0_addr;
        cmd_wdata_s = p0_wdata;
        if (win_id_s == PORT_DBG) begin
            cmd_we_s    = p1_we;
            cmd_addr_s  = p1_addr;
            cmd_wdata_s = p1_wdata;
        end else begin
            cmd_we_s    = p0_we;
            cmd_addr_s  = p0_addr;
            cmd_wdata_s = p0_wdata;
        end
    end

    // Next state plus the next value of every registered control output.
    always_comb begin
        state_s   = state_r;
        latch_s   = 1'b0;
        finish_s  = 1'b0;
        p0_gnt_s  = 1'b0;
        p1_gnt_s  = 1'b0;
        p0_done_s = 1'b0;
        p1_done_s = 1'b0;
        mem_en_s  = 1'b0;
        mem_wr_s  = 1'b0;
        busy_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_s  = ACCESS;
                    latch_s  = 1'b1;
                    mem_en_s = 1'b1;
                    mem_wr_s = cmd_we_s;
                    p0_gnt_s = (win_id_s == PORT_CPU);
                    p1_gnt_s = (win_id_s == PORT_DBG);
                    busy_s   = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            ACCESS: begin
                state_s   = DONE;
                finish_s  = 1'b1;
                p0_done_s = (win_id_r == PORT_CPU);
                p1_done_s = (win_id_r == PORT_DBG);
                busy_s    = 1'b1;
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Handshake and memory-control flops; reset drops mem_enable at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_gnt_r  <= 1'b0;
            p1_gnt_r  <= 1'b0;
            p0_done_r <= 1'b0;
            p1_done_r <= 1'b0;
            mem_en_r  <= 1'b0;
            mem_wr_r  <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            p0_gnt_r  <= p0_gnt_s;
            p1_gnt_r  <= p1_gnt_s;
            p0_done_r <= p0_done_s;
            p1_done_r <= p1_done_s;
            mem_en_r  <= mem_en_s;
            mem_wr_r  <= mem_wr_s;
            busy_r    <= busy_s;
        end
    end

    // Command registers, loaded once per transaction when leaving IDLE;
    // they double as the memory address/data drivers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_id_r <= PORT_CPU;
            addr_r   <= {ADDR_W{1'b0}};
            wdata_r  <= {DATA_W{1'b0}};
        end else if (latch_s) begin
            win_id_r <= win_id_s;
            addr_r   <= cmd_addr_s;
            wdata_r  <= cmd_wdata_s;
        end else begin
            win_id_r <= win_id_r;
            addr_r   <= addr_r;
            wdata_r  <= wdata_r;
        end
    end

    // Close of ACCESS: record the grant and capture load data for the winner.
    // mem_wr_r holds the latched write flag throughout ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= PORT_DBG;
            p0_rdata_r   <= {DATA_W{1'b0}};
            p1_rdata_r   <= {DATA_W{1'b0}};
        end else if (finish_s) begin
            last_grant_r <= win_id_r;
            if (!mem_wr_r) begin
                if (win_id_r == PORT_DBG) begin
                    p1_rdata_r <= mem_read_data;
                end else begin
                    p0_rdata_r <= mem_read_data;
                end
            end else begin
                p0_rdata_r <= p0_rdata_r;
                p1_rdata_r <= p1_rdata_r;
            end
        end else begin
            last_grant_r <= last_grant_r;
            p0_rdata_r   <= p0_rdata_r;
            p1_rdata_r   <= p1_rdata_r;
        end
    end

    assign p0_gnt         = p0_gnt_r;
    assign p1_gnt         = p1_gnt_r;
    assign p0_done        = p0_done_r;
    assign p1_done        = p1_done_r;
    assign p0_rdata       = p0_rdata_r;
    assign p1_rdata       = p1_rdata_r;
    assign mem_enable     = mem_en_r;
    assign mem_write      = mem_wr_r;
    assign mem_read_addr  = addr_r;
    assign mem_write_addr = addr_r;
    assign mem_write_data = wdata_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter. Instance "dut" runs round-robin and is
// tracked by a scoreboard; instance "dut_fx" runs fixed priority for the
// starvation scenario. Both sit on simple behavioural memories.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    typedef struct {
        logic       port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       p0_req, p0_we, p1_req, p1_we;
    logic [7:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic       p0_gnt, p0_done, p1_gnt, p1_done;
    logic [7:0] p0_rdata, p1_rdata;
    logic       mem_enable, mem_write, busy;
    logic [7:0] mem_read_addr, mem_write_addr, mem_write_data, mem_read_data;

    logic       b_p0_req, b_p0_we, b_p1_req, b_p1_we;
    logic [7:0] b_p0_addr, b_p0_wdata, b_p1_addr, b_p1_wdata;
    logic       b_p0_gnt, b_p0_done, b_p1_gnt, b_p1_done;
    logic [7:0] b_p0_rdata, b_p1_rdata;
    logic       b_mem_enable, b_mem_write, b_busy;
    logic [7:0] b_mem_read_addr, b_mem_write_addr, b_mem_write_data, b_mem_read_data;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] ref_mem [256];
    logic       mem_init_done = 1'b0;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [7:0] mon_obs;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic       lg_model;
    logic       first_gnt_port;
    logic       prev_g0, prev_g1;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .ARB_MODE(ARB_RR)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
        .mem_enable(mem_enable), .mem_write(mem_write),
        .mem_read_addr(mem_read_addr), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .busy(busy)
    );

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .ARB_MODE(ARB_FIXED)) dut_fx (
        .clk(clk), .rst_n(rst_n),
        .p0_req(b_p0_req), .p0_we(b_p0_we), .p0_addr(b_p0_addr), .p0_wdata(b_p0_wdata),
        .p0_gnt(b_p0_gnt), .p0_done(b_p0_done), .p0_rdata(b_p0_rdata),
        .p1_req(b_p1_req), .p1_we(b_p1_we), .p1_addr(b_p1_addr), .p1_wdata(b_p1_wdata),
        .p1_gnt(b_p1_gnt), .p1_done(b_p1_done), .p1_rdata(b_p1_rdata),
        .mem_enable(b_mem_enable), .mem_write(b_mem_write),
        .mem_read_addr(b_mem_read_addr), .mem_write_addr(b_mem_write_addr),
        .mem_write_data(b_mem_write_data), .mem_read_data(b_mem_read_data),
        .busy(b_busy)
    );

    // Behavioural data memories: combinational read, write on the clock edge.
    assign mem_read_data   = mem_a[mem_read_addr];
    assign b_mem_read_data = mem_b[b_mem_read_addr];

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= 8'h09;
                mem_b[i] <= 8'h09;
            end
            mem_init_done <= 1'b1;
        end else begin
            if (mem_enable && mem_write) mem_a[mem_write_addr] <= mem_write_data;
            if (b_mem_enable && b_mem_write) mem_b[b_mem_write_addr] <= b_mem_write_data;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard and invariant monitor for the round-robin instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_g0 = 1'b0;
            prev_g1 = 1'b0;
        end else begin
            checks++;
            if ((p0_gnt && p1_gnt) || (p0_done && p1_done) || (p0_gnt && p0_done) || (p1_gnt && p1_done)) begin
                errors++;
                $display("FAIL overlap: g0=%b g1=%b d0=%b d1=%b at cycle %0d", p0_gnt, p1_gnt, p0_done, p1_done, cyc);
            end
            checks++;
            if (p0_done !== prev_g0) begin
                errors++;
                $display("FAIL p0_done_follows_gnt: got %b expected %b at cycle %0d", p0_done, prev_g0, cyc);
            end
            checks++;
            if (p1_done !== prev_g1) begin
                errors++;
                $display("FAIL p1_done_follows_gnt: got %b expected %b at cycle %0d", p1_done, prev_g1, cyc);
            end
            checks++;
            if (mem_enable !== (p0_gnt | p1_gnt)) begin
                errors++;
                $display("FAIL mem_enable: got %b expected %b at cycle %0d", mem_enable, p0_gnt | p1_gnt, cyc);
            end
            checks++;
            if (busy !== (p0_gnt | p1_gnt | p0_done | p1_done)) begin
                errors++;
                $display("FAIL busy: got %b at cycle %0d", busy, cyc);
            end
            if (p0_gnt || p1_gnt) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_gnt: got g0=%b g1=%b expected none at cycle %0d", p0_gnt, p1_gnt, cyc);
                end else begin
                    mon_e = sb_q[0];
                    if ({p1_gnt, mem_write, mem_read_addr, mem_write_addr, mem_write_data} !==
                        {mon_e.port, mon_e.we, mon_e.addr, mon_e.addr, mon_e.wdata}) begin
                        errors++;
                        $display("FAIL access_cmd: got port=%b we=%b ra=%h wa=%h wd=%h expected port=%b we=%b a=%h wd=%h",
                                 p1_gnt, mem_write, mem_read_addr, mem_write_addr, mem_write_data,
                                 mon_e.port, mon_e.we, mon_e.addr, mon_e.wdata);
                    end
                end
            end
            if (p0_done || p1_done) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got d0=%b d1=%b expected none at cycle %0d", p0_done, p1_done, cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (p1_done !== mon_e.port) begin
                        errors++;
                        $display("FAIL done_port: got %b expected %b", p1_done, mon_e.port);
                    end
                    if (!mon_e.we) begin
                        checks++;
                        mon_obs = mon_e.port ? p1_rdata : p0_rdata;
                        if (mon_obs !== mon_e.rdata) begin
                            errors++;
                            $display("FAIL load_data: port %b addr %h got %h expected %h",
                                     mon_e.port, mon_e.addr, mon_obs, mon_e.rdata);
                        end
                    end
                end
            end
            prev_g0 = p0_gnt;
            prev_g1 = p1_gnt;
        end
    end

    // Queue one expected transaction, advancing the reference memory.
    task automatic push_exp(input logic port, input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        exp_t e;
        e.port  = port;
        e.we    = we;
        e.addr  = addr;
        e.wdata = wdata;
        e.rdata = ref_mem[addr];
        if (we) ref_mem[addr] = wdata;
        sb_q.push_back(e);
        lg_model = port;
    endtask

    // Issue requests on either/both ports and follow the requester protocol.
    task automatic run_txn(input logic r0, input logic r1, input logic we0, input logic we1,
                           input logic [7:0] a0, input logic [7:0] d0,
                           input logic [7:0] a1, input logic [7:0] d1);
        logic first;
        int   n;
        first = (r0 && r1) ? ~lg_model : r1;
        if (first == PORT_CPU) begin
            if (r0) push_exp(PORT_CPU, we0, a0, d0);
            if (r1) push_exp(PORT_DBG, we1, a1, d1);
        end else begin
            if (r1) push_exp(PORT_DBG, we1, a1, d1);
            if (r0) push_exp(PORT_CPU, we0, a0, d0);
        end
        p0_we = we0; p0_addr = a0; p0_wdata = d0;
        p1_we = we1; p1_addr = a1; p1_wdata = d1;
        p0_req = r0; p1_req = r1;
        first_gnt_port = 1'bx;
        n = 0;
        while ((p0_req || p1_req) && n < 20) begin
            @(posedge clk); #1;
            n++;
            if ((p0_gnt || p1_gnt) && first_gnt_port === 1'bx) first_gnt_port = p1_gnt;
            if (p0_done) p0_req = 1'b0;
            if (p1_done) p1_req = 1'b0;
        end
        if (p0_req || p1_req) begin
            checks++;
            errors++;
            $display("FAIL txn_timeout: req0=%b req1=%b still waiting after %0d cycles", p0_req, p1_req, n);
            p0_req = 1'b0;
            p1_req = 1'b0;
            sb_q.delete();
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({p0_gnt, p0_done, p0_rdata, p1_gnt, p1_done, p1_rdata, mem_enable, mem_write,
             mem_read_addr, mem_write_addr, mem_write_data, busy} !== 47'd0) begin
            errors++;
            $display("FAIL reset_outputs: outputs not all zero during reset (busy=%b en=%b)", busy, mem_enable);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({p0_gnt, p0_done, p0_rdata, p1_gnt, p1_done, p1_rdata, mem_enable, mem_write,
                 mem_read_addr, mem_write_addr, mem_write_data, busy, b_busy, b_mem_enable} !== 49'd0) begin
                errors++;
                $display("FAIL idle_outputs: cycle %0d after release, busy=%b en=%b expected all zero", i, busy, mem_enable);
            end
        end
    endtask

    task automatic test_single_store_load;
        push_exp(PORT_CPU, 1'b1, 8'h10, 8'hA5);
        p0_we = 1'b1; p0_addr = 8'h10; p0_wdata = 8'hA5; p0_req = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({p0_gnt, p1_gnt, mem_enable, mem_write, mem_read_addr, mem_write_addr, mem_write_data} !==
            {1'b1, 1'b0, 1'b1, 1'b1, 8'h10, 8'h10, 8'hA5}) begin
            errors++;
            $display("FAIL store_access: got gnt=%b en=%b wr=%b ra=%h wa=%h wd=%h expected 1 1 1 10 10 a5",
                     p0_gnt, mem_enable, mem_write, mem_read_addr, mem_write_addr, mem_write_data);
        end
        @(posedge clk); #1;
        checks++;
        if ({p0_done, p0_gnt, mem_enable, mem_write} !== 4'b1000) begin
            errors++;
            $display("FAIL store_done: got done=%b gnt=%b en=%b wr=%b expected 1 0 0 0", p0_done, p0_gnt, mem_enable, mem_write);
        end
        p0_req = 1'b0;
        @(posedge clk); #1;
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 8'h00);
        checks++;
        if ({p0_done, p0_rdata} !== {1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL load_after_store: got done=%b rdata=%h expected 1 a5", p0_done, p0_rdata);
        end
    endtask

    task automatic test_uninit_read;
        @(posedge clk); #1;
        run_txn(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFF, 8'h00);
        checks++;
        if ({p1_done, p1_rdata} !== {1'b1, 8'h09}) begin
            errors++;
            $display("FAIL uninit_read: got done=%b rdata=%h expected 1 09", p1_done, p1_rdata);
        end
        checks++;
        if ({p0_gnt, p0_done, p0_rdata} !== {1'b0, 1'b0, 8'hA5}) begin
            errors++;
            $display("FAIL p0_unchanged: got gnt=%b done=%b rdata=%h expected 0 0 a5", p0_gnt, p0_done, p0_rdata);
        end
    endtask

    task automatic test_rr_contention;
        int   gcyc[$];
        logic gport[$];
        int   dones;
        int   n;
        logic pt;
        for (int i = 0; i < 4; i++) begin
            pt = ~lg_model;
            push_exp(pt, 1'b0, pt ? 8'h20 : 8'h10, 8'h00);
        end
        p0_we = 1'b0; p0_addr = 8'h10; p0_wdata = 8'h00;
        p1_we = 1'b0; p1_addr = 8'h20; p1_wdata = 8'h00;
        p0_req = 1'b1; p1_req = 1'b1;
        dones = 0;
        n = 0;
        while (dones < 4 && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (p0_gnt || p1_gnt) begin
                gcyc.push_back(cyc);
                gport.push_back(p1_gnt);
            end
            if (p0_done || p1_done) dones++;
        end
        p0_req = 1'b0; p1_req = 1'b0;
        checks++;
        if (gport.size() != 4) begin
            errors++;
            $display("FAIL rr_grant_count: got %0d expected 4", gport.size());
        end
        for (int i = 0; i < 4 && i < gport.size(); i++) begin
            checks++;
            if (gport[i] !== ((i % 2) == 1)) begin
                errors++;
                $display("FAIL rr_order: grant %0d got port %b expected %b", i, gport[i], (i % 2) == 1);
            end
            if (i > 0) begin
                checks++;
                if (gcyc[i] - gcyc[i-1] != 3) begin
                    errors++;
                    $display("FAIL rr_spacing: grant %0d got %0d cycles expected 3", i, gcyc[i] - gcyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_fixed_priority;
        int gcyc[$];
        int p1_grants;
        int dones;
        int n;
        b_p0_we = 1'b0; b_p0_addr = 8'h30; b_p0_wdata = 8'h00;
        b_p1_we = 1'b0; b_p1_addr = 8'h31; b_p1_wdata = 8'h00;
        b_p0_req = 1'b1; b_p1_req = 1'b1;
        p1_grants = 0;
        dones = 0;
        n = 0;
        while (dones < 4 && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (b_p0_gnt) gcyc.push_back(cyc);
            if (b_p1_gnt) p1_grants++;
            if (b_p0_done) begin
                dones++;
                checks++;
                if (b_p0_rdata !== 8'h09) begin
                    errors++;
                    $display("FAIL fixed_load_data: got %h expected 09", b_p0_rdata);
                end
            end
        end
        b_p0_req = 1'b0; b_p1_req = 1'b0;
        checks++;
        if (gcyc.size() != 4 || p1_grants != 0) begin
            errors++;
            $display("FAIL fixed_grants: got p0=%0d p1=%0d expected p0=4 p1=0", gcyc.size(), p1_grants);
        end
        for (int i = 1; i < gcyc.size(); i++) begin
            checks++;
            if (gcyc[i] - gcyc[i-1] != 3) begin
                errors++;
                $display("FAIL fixed_spacing: grant %0d got %0d cycles expected 3", i, gcyc[i] - gcyc[i-1]);
            end
        end
    endtask

    task automatic test_reset_mid_access;
        int n;
        @(posedge clk); #1;
        p1_we = 1'b1; p1_addr = 8'hEE; p1_wdata = 8'h5A; p1_req = 1'b1;
        n = 0;
        while (!p1_gnt && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (p1_gnt !== 1'b1) begin
            errors++;
            $display("FAIL midreset_gnt: got %b expected 1", p1_gnt);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_enable, mem_write, p1_gnt, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_drop: got en=%b wr=%b gnt=%b busy=%b expected 0 0 0 0", mem_enable, mem_write, p1_gnt, busy);
        end
        p1_req = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if ({p1_done, busy} !== 2'b00) begin
                errors++;
                $display("FAIL midreset_no_done: got done=%b busy=%b expected 0 0", p1_done, busy);
            end
        end
        @(negedge clk) rst_n = 1'b1;
        sb_q.delete();
        lg_model = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle: got busy=%b expected 0", busy);
        end
        run_txn(1'b1, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 8'h20, 8'h00);
        checks++;
        if (first_gnt_port !== PORT_CPU) begin
            errors++;
            $display("FAIL midreset_first_tie: got port %b expected 0", first_gnt_port);
        end
    endtask

    task automatic test_random_traffic;
        int   txns;
        int   pat;
        logic r0, r1;
        txns = 0;
        while (txns < 1000) begin
            pat = $urandom_range(0, 2);
            r0 = (pat != 1);
            r1 = (pat != 0);
            run_txn(r0, r1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 63)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
            txns += int'(r0) + int'(r1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = 8'h00; p0_wdata = 8'h00;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 8'h00; p1_wdata = 8'h00;
        b_p0_req = 1'b0; b_p0_we = 1'b0; b_p0_addr = 8'h00; b_p0_wdata = 8'h00;
        b_p1_req = 1'b0; b_p1_we = 1'b0; b_p1_addr = 8'h00; b_p1_wdata = 8'h00;
        lg_model = 1'b1;
        first_gnt_port = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h09;

        test_reset();
        test_single_store_load();
        test_uninit_read();
        test_rr_contention();
        test_fixed_priority();
        test_reset_mid_access();
        test_random_traffic();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer for the 8-bit data memory. It shares the single memory between the CPU load/store port (port 0) and the debug/loader port (port 1). Each access runs a fixed 3-state transaction: IDLE, ACCESS, DONE. The block sits between the core's execute stage or debug loader and data_memory, and is the only driver of the memory's enable, write, address and data inputs.

Parameters:
ADDR_W, 8, address width; matches data_memory.
DATA_W, 8, data width; matches data_memory.
ARB_MODE, 1, 0 = fixed priority with port 0 winning; 1 = round-robin.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
p0_req  in  1  port 0 request; held high until p0_done.
p0_we  in  1  port 0 write enable (1 = store, 0 = load).
p0_addr  in  ADDR_W  port 0 address.
p0_wdata  in  DATA_W  port 0 store data.
p0_gnt  out  1  one-cycle pulse: port 0 access is in progress.
p0_done  out  1  one-cycle pulse: port 0 transaction is complete.
p0_rdata  out  DATA_W  load result; valid while p0_done = 1.
p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_done, p1_rdata: same as the port 0 signals, for port 1.
mem_enable  out  1  to data_memory.
mem_write  out  1  to data_memory.
mem_read_addr  out  ADDR_W  to data_memory read_addr.
mem_write_addr  out  ADDR_W  to data_memory write_addr.
mem_write_data  out  DATA_W  to data_memory write_data.
mem_read_data  in  DATA_W  from data_memory read_data; combinational read.
busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: asynchronous, active-low. While rst_n = 0:
  - state = IDLE, all gnt/done/busy/mem_enable/mem_write = 0;
  - all address, data and rdata outputs = 0;
  - last_grant = 1, so port 0 wins the first round-robin tie.
- Glitch-free memory control: data_memory writes combinationally. mem_enable, mem_write and all memory address/data outputs are driven directly from flops, never from decode logic.
- IDLE:
  - If no request, stay in IDLE.
  - If any req is high, choose a winner:
    - ARB_MODE = 0: port 0 wins whenever p0_req = 1.
    - ARB_MODE = 1: if both ports request, the port that is not last_grant wins; a single requester always wins.
  - Latch the winner's we, addr and wdata into the command registers, set win_id, and go to ACCESS.
- ACCESS, exactly 1 cycle:
  - mem_enable = 1, mem_write = latched we;
  - both memory addresses = latched addr; mem_write_data = latched wdata;
  - p{win_id}_gnt = 1;
  - at the closing edge, capture mem_read_data into the winner's rdata register (loads only; stores leave rdata unchanged), update last_grant = win_id, and go to DONE.
- DONE, exactly 1 cycle:
  - mem_enable = 0, mem_write = 0;
  - p{win_id}_done = 1;
  - go to IDLE.
- Latency: req sampled in IDLE at edge k; gnt during cycle k+1; done and rdata valid during cycle k+2. Next grant is no earlier than edge k+3. Throughput is one access per 3 cycles.
- Requester rule: a requester deasserts req at the edge following its done. Because IDLE only samples at the next edge, no spurious re-grant occurs. Requester inputs are don't-care outside IDLE, since the command is latched.
- pX_rdata holds its last captured value until the next load on that port.
- Simultaneous requests in ARB_MODE = 1: strict alternation while both are held.
- Store followed by load to the same address: the load returns the stored data, because transactions are serialised.
- Reset during ACCESS: mem_enable drops immediately (asynchronously). The in-flight store may or may not be committed; no done is issued.
- Invariants: gnt and done are never asserted on both ports in the same cycle. gnt and done are never both high for the same port.

Decomposition:
- Shared package dmem_pkg holds:
  - state encoding: IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2;
  - ARB_FIXED = 0, ARB_RR = 1;
  - port ids PORT_CPU = 0, PORT_DBG = 1.
- One natural sub-module, dmem_rr_pick: combinational winner selection from p0_req, p1_req, last_grant and ARB_MODE. It outputs win_id and any_req.
- The FSM, command registers and output flops stay in dmem_arbiter.

Test Plan:
- Reset then idle: hold rst_n = 0 for 3 cycles, release, run 5 cycles with no req -> all outputs 0, busy = 0, mem_enable never high.
- Single store/load: p0 store addr 0x10 data 0xA5, then load 0x10:
  - p0_gnt one cycle after req, with mem_enable = 1, mem_write = 1, addresses = 0x10;
  - p0_done on the next cycle;
  - after the load, p0_rdata = 0xA5 while p0_done = 1.
- Uninitialised read: p1 load addr 0xFF -> p1_rdata = 0x09 (memory default), with p0 outputs unchanged.
- Contention, ARB_MODE = 1: p0 and p1 both request loads continuously for 4 transactions -> grant order 0, 1, 0, 1, each 3 cycles apart. Repeat with ARB_MODE = 0 -> grant order 0, 0, 0, 0 and p1 starves while p0 is held.
- Reset mid-ACCESS: assert rst_n = 0 during a p1 store ACCESS cycle -> mem_enable = 0 in the same cycle, no p1_done, state IDLE after release, first tie after release granted to p0.
- Invariant checks across random traffic (1000 transactions, memory reference model):
  - gnt/done never overlap across ports;
  - every gnt is followed by exactly one done of the same port;
  - read data matches the memory reference model.
